// File: rtl/maze_controller_if.sv
// Signal bundle between the maze search sequencer, its datapath and the cell RAM.
// The controller takes the master side; the datapath/RAM environment takes the slave side.
interface maze_controller_if;
  logic        start;
  logic [7:0]  nxtLoc;
  logic        cntReach;
  logic        empStck;
  logic [1:0]  memDout;
  logic [7:0]  curLoc;
  logic [1:0]  dir;
  logic        rgLd;
  logic        push;
  logic        pop;
  logic        readFromStack;
  logic        memRd;
  logic        memWr;
  logic [7:0]  memAddr;
  logic        busy;
  logic        done;
  logic        fail;
  logic [15:0] stepCnt;

  modport master (
    input  start, nxtLoc, cntReach, empStck, memDout,
    output curLoc, dir, rgLd, push, pop, readFromStack,
    output memRd, memWr, memAddr, busy, done, fail, stepCnt
  );

  modport slave (
    output start, nxtLoc, cntReach, empStck, memDout,
    input  curLoc, dir, rgLd, push, pop, readFromStack,
    input  memRd, memWr, memAddr, busy, done, fail, stepCnt
  );
endinterface

// File: rtl/maze_controller.sv
// Depth-first maze search sequencer: TRY+EVAL per probed cell, ADVANCE+MARK per step.
// No backpressure; start is honoured only when idle, done or failed.
module maze_controller #(
  parameter logic [7:0]  START_LOC = 8'h00,
  parameter logic [7:0]  GOAL_LOC  = 8'hFF,
  parameter logic [15:0] MAX_STEPS = 16'hFFFF
) (
  input logic               clk,
  input logic               rst,
  maze_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT    = 4'd1,
    S_GOAL    = 4'd2,
    S_TRY     = 4'd3,
    S_EVAL    = 4'd4,
    S_NEXTDIR = 4'd5,
    S_ADVANCE = 4'd6,
    S_MARK    = 4'd7,
    S_BACK    = 4'd8,
    S_DONE    = 4'd9,
    S_FAIL    = 4'd10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cur_loc;
  logic [1:0]  dir;
  logic [15:0] step_cnt;
  logic [15:0] step_nxt;
  logic        cell_blocked;
  logic        accept_start;

  assign cell_blocked = bus.memDout[0] | bus.memDout[1];
  assign accept_start = bus.start &&
                        (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  // Saturate so the GOAL check always sees the exact budget value.
  assign step_nxt     = (step_cnt >= MAX_STEPS) ? step_cnt : step_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_INIT;
      end
      S_INIT: begin
        state_d = S_GOAL;
      end
      S_GOAL: begin
        if (cur_loc == GOAL_LOC) begin
          state_d = S_DONE;
        end else if (step_cnt >= MAX_STEPS) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_TRY;
        end
      end
      S_TRY: begin
        state_d = bus.cntReach ? S_NEXTDIR : S_EVAL;
      end
      S_EVAL: begin
        state_d = cell_blocked ? S_NEXTDIR : S_ADVANCE;
      end
      S_NEXTDIR: begin
        state_d = (dir == 2'd3) ? S_BACK : S_TRY;
      end
      S_ADVANCE: begin
        state_d = S_MARK;
      end
      S_MARK: begin
        state_d = S_GOAL;
      end
      S_BACK: begin
        state_d = bus.empStck ? S_FAIL : S_GOAL;
      end
      S_DONE, S_FAIL: begin
        if (bus.start) state_d = S_INIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_loc  <= START_LOC;
      dir      <= 2'd0;
      step_cnt <= 16'd0;
    end else begin
      if (accept_start) begin
        cur_loc  <= START_LOC;
        dir      <= 2'd0;
        step_cnt <= 16'd0;
      end else begin
        case (state_q)
          S_GOAL: begin
            dir <= 2'd0;
          end
          S_NEXTDIR: begin
            if (dir != 2'd3) dir <= dir + 2'd1;
          end
          S_ADVANCE: begin
            cur_loc  <= bus.nxtLoc;
            step_cnt <= step_nxt;
          end
          S_BACK: begin
            // nxtLoc carries the stack top while readFromStack is asserted.
            if (!bus.empStck) begin
              cur_loc  <= bus.nxtLoc;
              step_cnt <= step_nxt;
              dir      <= 2'd0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.rgLd          = 1'b0;
    bus.push          = 1'b0;
    bus.pop           = 1'b0;
    bus.readFromStack = 1'b0;
    bus.memRd         = 1'b0;
    bus.memWr         = 1'b0;
    bus.memAddr       = bus.nxtLoc;
    bus.busy          = 1'b1;
    bus.done          = 1'b0;
    bus.fail          = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
      end
      S_INIT, S_MARK: begin
        bus.memWr   = 1'b1;
        bus.memAddr = cur_loc;
      end
      S_TRY: begin
        bus.memRd = !bus.cntReach;
      end
      S_ADVANCE: begin
        bus.push = 1'b1;
        bus.rgLd = 1'b1;
      end
      S_BACK: begin
        bus.readFromStack = 1'b1;
        bus.pop           = !bus.empStck;
      end
      S_DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      S_FAIL: begin
        bus.busy = 1'b0;
        bus.fail = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.curLoc  = cur_loc;
  assign bus.dir     = dir;
  assign bus.stepCnt = step_cnt;

  a_push_pop_excl: assert property (@(posedge clk) disable iff (!rst)
                                    !(bus.push && bus.pop));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst)
                                 !(bus.memRd && bus.memWr));

endmodule

// File: tb/tb_maze_controller.sv
// Bench for maze_controller: two instances (full and 8-step budget) with a
// datapath/stack/cell-RAM environment, directed maze table plus random mazes vs a DFS model.
module tb_maze_controller;

  logic clk;
  logic rst;

  logic [1:0]   start_v;
  logic [1:0]   clr_v;
  logic [255:0] wmask [2];

  wire [1:0]  busy_w, done_w, fail_w, memrd_w, memwr_w, push_w, pop_w;
  wire [7:0]  cur_w      [2];
  wire [1:0]  dir_w      [2];
  wire [15:0] stp_w      [2];
  wire [15:0] push_n_w   [2];
  wire [15:0] pop_n_w    [2];
  wire [15:0] viol_w     [2];
  wire [7:0]  first_rd_w [2];
  wire [7:0]  pl0_w      [2];
  wire [7:0]  pl1_w      [2];

  int n_pass = 0;
  int n_tot  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Neighbour of loc in direction d; bit 8 set when the move leaves the grid.
  function automatic logic [8:0] step_to(input logic [7:0] l, input logic [1:0] d);
    logic [8:0] r;
    case (d)
      2'd0:    r = (l[3:0] == 4'h0) ? {1'b1, l} : {1'b0, l - 8'h01};
      2'd1:    r = (l[7:4] == 4'hF) ? {1'b1, l} : {1'b0, l + 8'h10};
      2'd2:    r = (l[7:4] == 4'h0) ? {1'b1, l} : {1'b0, l - 8'h10};
      default: r = (l[3:0] == 4'hF) ? {1'b1, l} : {1'b0, l + 8'h01};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam logic [15:0] MAXS = (g == 0) ? 16'hFFFF : 16'd8;

    maze_controller_if mif ();

    maze_controller #(
      .START_LOC(8'h00),
      .GOAL_LOC (8'hFF),
      .MAX_STEPS(MAXS)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(mif)
    );

    logic [1:0]  ram [256];
    logic [7:0]  stk [256];
    logic [8:0]  sp;
    logic [1:0]  rd_q;
    logic [8:0]  nb;
    logic [15:0] push_n, pop_n, viol_n;
    logic [7:0]  first_rd, pl0, pl1;
    logic        seen_rd, pop_d;

    assign nb           = step_to(mif.curLoc, mif.dir);
    assign mif.start    = start_v[g];
    assign mif.cntReach = nb[8];
    assign mif.empStck  = (sp == 9'd0);
    assign mif.nxtLoc   = mif.readFromStack ? ((sp == 9'd0) ? 8'h00 : stk[sp[7:0] - 8'd1]) : nb[7:0];
    assign mif.memDout  = rd_q;

    always_ff @(posedge clk) begin
      if (clr_v[g]) begin
        for (int i = 0; i < 256; i++) ram[i] <= {1'b0, wmask[g][i]};
        sp       <= 9'd0;
        rd_q     <= 2'b00;
        push_n   <= 16'd0;
        pop_n    <= 16'd0;
        viol_n   <= 16'd0;
        first_rd <= 8'h00;
        pl0      <= 8'h00;
        pl1      <= 8'h00;
        seen_rd  <= 1'b0;
        pop_d    <= 1'b0;
      end else begin
        if (mif.push) begin
          stk[sp[7:0]] <= mif.curLoc;
          sp           <= sp + 9'd1;
          push_n       <= push_n + 16'd1;
        end else if (mif.pop) begin
          sp <= sp - 9'd1;
        end
        if (mif.memRd) begin
          rd_q <= ram[mif.memAddr];
          if (!seen_rd) first_rd <= mif.memAddr;
          seen_rd <= 1'b1;
        end
        if (mif.memWr) ram[mif.memAddr][1] <= 1'b1;
        if ((mif.push && mif.pop) || (mif.memRd && mif.memWr)) viol_n <= viol_n + 16'd1;
        pop_d <= mif.pop;
        if (pop_d) begin
          if (pop_n == 16'd0) pl0 <= mif.curLoc;
          if (pop_n == 16'd1) pl1 <= mif.curLoc;
          pop_n <= pop_n + 16'd1;
        end
      end
    end

    assign busy_w[g]     = mif.busy;
    assign done_w[g]     = mif.done;
    assign fail_w[g]     = mif.fail;
    assign memrd_w[g]    = mif.memRd;
    assign memwr_w[g]    = mif.memWr;
    assign push_w[g]     = mif.push;
    assign pop_w[g]      = mif.pop;
    assign cur_w[g]      = mif.curLoc;
    assign dir_w[g]      = mif.dir;
    assign stp_w[g]      = mif.stepCnt;
    assign push_n_w[g]   = push_n;
    assign pop_n_w[g]    = pop_n;
    assign viol_w[g]     = viol_n;
    assign first_rd_w[g] = first_rd;
    assign pl0_w[g]      = pl0;
    assign pl1_w[g]      = pl1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Plain DFS over (row, col) = (hi, lo): directions tried lo-1, hi+1, hi-1, lo+1,
  // restarting at lo-1 after every advance or backtrack.
  function automatic void model(input logic [255:0] w, input int maxs, output bit ok,
                                output int steps, output int pushes, output logic [7:0] loc);
    bit vis [256];
    int stack [$];
    int dr [4] = '{0, 1, -1, 0};
    int dc [4] = '{-1, 0, 0, 1};
    int cur;
    bit moved;
    for (int i = 0; i < 256; i++) vis[i] = 1'b0;
    cur = 0; vis[0] = 1'b1; steps = 0; pushes = 0; ok = 1'b0;
    while (1) begin
      if (cur == 255) begin ok = 1'b1; break; end
      if (steps == maxs) begin ok = 1'b0; break; end
      moved = 1'b0;
      for (int d = 0; d < 4; d++) begin
        int nr, nc, n;
        nr = cur / 16 + dr[d];
        nc = cur % 16 + dc[d];
        if (nr >= 0 && nr < 16 && nc >= 0 && nc < 16) begin
          n = nr * 16 + nc;
          if (!w[n] && !vis[n]) begin
            stack.push_back(cur);
            cur = n; vis[n] = 1'b1; steps++; pushes++; moved = 1'b1;
            break;
          end
        end
      end
      if (!moved) begin
        if (stack.size() == 0) begin ok = 1'b0; break; end
        cur = stack.pop_back();
        steps++;
      end
    end
    loc = cur[7:0];
  endfunction

  task automatic load_and_start(input int idx, input logic [255:0] m);
    @(negedge clk);
    wmask[idx] = m;
    clr_v[idx] = 1'b1;
    @(negedge clk);
    clr_v[idx]   = 1'b0;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic run(input int idx, input logic [255:0] m, input string nm, output bit to);
    load_and_start(idx, m);
    chk($sformatf("%s start_status", nm),
        {busy_w[idx], done_w[idx], fail_w[idx], stp_w[idx]}, {3'b100, 16'd0});
    to = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (!busy_w[idx]) begin to = 1'b0; break; end
      start_v[idx] = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    start_v[idx] = 1'b0;
    chk($sformatf("%s timeout", nm), {31'd0, to}, 32'd0);
    chk($sformatf("%s excl_violations", nm), {16'd0, viol_w[idx]}, 32'd0);
  endtask

  typedef struct {
    string        name;
    int           inst;
    logic [255:0] walls;
    bit           exp_done;
    logic [7:0]   exp_loc;
    int           exp_steps;
    int           exp_push;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [255:0] m;
    bit           to, ok, hit;
    int           st, pu, dens, idx;
    logic [7:0]   lc;

    rst = 1'b0;
    start_v = 2'b00;
    clr_v = 2'b00;
    wmask[0] = '0;
    wmask[1] = '0;

    m = '0;
    tbl[0] = '{"empty", 0, m, 1'b1, 8'hFF, 240, 240};
    m = '0; m[8'h10] = 1'b1; m[8'h01] = 1'b1;
    tbl[1] = '{"boxed_start", 0, m, 1'b0, 8'h00, 0, 0};
    m = '0; m[8'h01] = 1'b1; m[8'h11] = 1'b1; m[8'h21] = 1'b1; m[8'h30] = 1'b1;
    tbl[2] = '{"dead_end", 0, m, 1'b0, 8'h00, 4, 2};
    m = '0;
    tbl[3] = '{"budget8", 1, m, 1'b0, 8'h80, 8, 8};

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_loc_dir_%0d", i), {cur_w[i], dir_w[i]}, {8'h00, 2'b00});
      chk($sformatf("reset_step_%0d", i), {16'd0, stp_w[i]}, 32'd0);
      chk($sformatf("reset_flags_%0d", i),
          {busy_w[i], done_w[i], fail_w[i], memrd_w[i], memwr_w[i], push_w[i], pop_w[i]}, 7'd0);
    end
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run(tbl[i].inst, tbl[i].walls, tbl[i].name, to);
      idx = tbl[i].inst;
      chk($sformatf("%s done_fail", tbl[i].name), {done_w[idx], fail_w[idx]},
          {tbl[i].exp_done, !tbl[i].exp_done});
      chk($sformatf("%s cur_loc", tbl[i].name), {24'd0, cur_w[idx]}, {24'd0, tbl[i].exp_loc});
      chk($sformatf("%s step_cnt", tbl[i].name), {16'd0, stp_w[idx]}, tbl[i].exp_steps);
      chk($sformatf("%s push_count", tbl[i].name), {16'd0, push_n_w[idx]}, tbl[i].exp_push);
      if (i == 0) chk("first_read_addr", {24'd0, first_rd_w[0]}, 32'h10);
      if (i == 2) begin
        chk("dead_end pop_count", {16'd0, pop_n_w[0]}, 32'd2);
        chk("dead_end pop_locs", {pl0_w[0], pl1_w[0]}, {8'h10, 8'h00});
      end
    end

    // Async reset while probing a cell mid-search.
    load_and_start(0, '0);
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (stp_w[0] >= 16'd5 && memrd_w[0]) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_reached_try", {31'd0, hit}, 32'd1);
    chk("pre_rst_loc", {24'd0, cur_w[0]}, 32'h50);
    #2 rst = 1'b0;
    #1;
    chk("midrst_loc_dir", {cur_w[0], dir_w[0]}, {8'h00, 2'b00});
    chk("midrst_step", {16'd0, stp_w[0]}, 32'd0);
    chk("midrst_flags",
        {busy_w[0], done_w[0], fail_w[0], memrd_w[0], memwr_w[0], push_w[0], pop_w[0]}, 7'd0);
    @(negedge clk);
    rst = 1'b1;
    run(0, '0, "after_rst", to);
    chk("after_rst done_fail", {done_w[0], fail_w[0]}, 2'b10);
    chk("after_rst step_cnt", {16'd0, stp_w[0]}, 32'd240);

    for (int k = 0; k < 8; k++) begin
      idx  = (k < 6) ? 0 : 1;
      dens = 8 + 5 * k;
      for (int c = 0; c < 256; c++) m[c] = ($urandom_range(0, 99) < dens);
      m[0] = 1'b0;
      model(m, (idx == 0) ? 65535 : 8, ok, st, pu, lc);
      run(idx, m, $sformatf("rand%0d", k), to);
      chk($sformatf("rand%0d done_fail", k), {done_w[idx], fail_w[idx]}, {ok, !ok});
      chk($sformatf("rand%0d cur_loc", k), {24'd0, cur_w[idx]}, {24'd0, lc});
      chk($sformatf("rand%0d step_cnt", k), {16'd0, stp_w[idx]}, st);
      chk($sformatf("rand%0d push_count", k), {16'd0, push_n_w[idx]}, pu);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
